// File: rtl/hid_report_collector.sv
// Latest-report store, change/stale flags and a round-robin event stream for N HID host channels.
// Define HID_COLLECTOR_OVERRUN_EN to add per-channel overrun counters on overrun_o.
module hid_report_collector #(
  parameter int unsigned C_channels     = 2,
  parameter int unsigned C_report_bytes = 8,
  parameter int unsigned C_disp_bytes   = 8,
  parameter int unsigned C_timeout_bits = 24,
  localparam int unsigned CW = (C_channels > 1) ? $clog2(C_channels) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic [C_channels*C_report_bytes*8-1:0] hid_report_i,
  input  logic [C_channels-1:0]                hid_valid_i,
  input  logic                                 freeze_i,
  input  logic                                 clear_i,
  output logic [C_channels*C_disp_bytes*8-1:0] display_o,
  output logic [C_channels-1:0]                changed_o,
  output logic [C_channels-1:0]                stale_o,
  output logic                                 evt_valid_o,
  input  logic                                 evt_ready_i,
  output logic [CW-1:0]                        evt_chan_o,
  output logic [C_report_bytes*8-1:0]          evt_report_o
`ifdef HID_COLLECTOR_OVERRUN_EN
  ,
  output logic [C_channels*8-1:0]              overrun_o
`endif
);

  localparam int unsigned RW = C_report_bytes * 8;
  localparam int unsigned DW = C_disp_bytes * 8;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e                    state_q;
  logic [RW-1:0]             store_q [C_channels];
  logic [RW-1:0]             store_d [C_channels];
  logic [C_timeout_bits-1:0] cnt_q   [C_channels];
  logic [C_channels-1:0]     changed_q;
  logic [C_channels-1:0]     cap, diff, acc;
  logic [CW-1:0]             rr_q, rr_next, grant, grant_lo, grant_hi;
  logic                      grant_found, hi_found;
  logic                      evt_valid_q;
  logic [CW-1:0]             evt_chan_q;
  logic [RW-1:0]             evt_report_q;

  always_comb begin
    for (int k = 0; k < C_channels; k++) begin
      cap[k]     = hid_valid_i[k] & ~freeze_i;
      diff[k]    = cap[k] & (hid_report_i[k*RW +: RW] != store_q[k]);
      store_d[k] = cap[k] ? hid_report_i[k*RW +: RW] : store_q[k];
      acc[k]     = evt_valid_q & evt_ready_i & (evt_chan_q == CW'(k));
    end
  end

  // Descending scan leaves the lowest set index overall and the lowest one at or above rr_q.
  always_comb begin
    grant_lo = '0;
    grant_hi = '0;
    hi_found = 1'b0;
    for (int k = C_channels - 1; k >= 0; k--) begin
      if (changed_q[k]) begin
        grant_lo = CW'(k);
        if (k >= int'(rr_q)) begin
          grant_hi = CW'(k);
          hi_found = 1'b1;
        end
      end
    end
    grant       = hi_found ? grant_hi : grant_lo;
    grant_found = |changed_q;
    rr_next     = (evt_chan_q == CW'(C_channels - 1)) ? '0 : evt_chan_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < C_channels; k++) begin
      if (!rstn_i || hid_valid_i[k]) begin
        cnt_q[k] <= '0;
      end else if (cnt_q[k] != '1) begin
        cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  // Set from a differing capture wins over clear-on-accept.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || clear_i) begin
      for (int k = 0; k < C_channels; k++) store_q[k] <= '0;
      changed_q <= '0;
    end else begin
      for (int k = 0; k < C_channels; k++) store_q[k] <= store_d[k];
      changed_q <= (changed_q & ~acc) | diff;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= StIdle;
      evt_valid_q  <= 1'b0;
      evt_chan_q   <= '0;
      evt_report_q <= '0;
      rr_q         <= '0;
    end else if (clear_i) begin
      state_q     <= StIdle;
      evt_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_found) begin
            evt_chan_q   <= grant;
            evt_report_q <= store_d[grant];
            evt_valid_q  <= 1'b1;
            state_q      <= StHold;
          end
        end
        StHold: begin
          if (evt_ready_i) begin
            evt_valid_q <= 1'b0;
            rr_q        <= rr_next;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    display_o = '0;
    stale_o   = '0;
    for (int k = 0; k < C_channels; k++) begin
      display_o[k*DW +: DW] = store_q[k][DW-1:0];
      stale_o[k]            = (cnt_q[k] == '1);
    end
  end

  assign changed_o    = changed_q;
  assign evt_valid_o  = evt_valid_q;
  assign evt_chan_o   = evt_chan_q;
  assign evt_report_o = evt_report_q;

`ifdef HID_COLLECTOR_OVERRUN_EN
  logic [7:0] ovr_q [C_channels];

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < C_channels; k++) begin
      if (!rstn_i || clear_i) begin
        ovr_q[k] <= '0;
      end else if (diff[k] && changed_q[k] && !acc[k] && (ovr_q[k] != 8'hFF)) begin
        ovr_q[k] <= ovr_q[k] + 1'b1;
      end
    end
  end

  always_comb begin
    overrun_o = '0;
    for (int k = 0; k < C_channels; k++) overrun_o[k*8 +: 8] = ovr_q[k];
  end
`endif

endmodule

// File: tb/tb_hid_report_collector.sv
// Bench for hid_report_collector: vector table, directed corner sequences and a randomized
// phase checked every cycle against a behavioural model.
module tb_hid_report_collector;

  localparam int C = 3;
  localparam int STALE_MAX = 15;

  logic          clk;
  logic          rstn;
  logic [191:0]  hid_report;
  logic [2:0]    hid_valid;
  logic          freeze;
  logic          clear;
  logic [191:0]  display;
  logic [2:0]    changed;
  logic [2:0]    stale;
  logic          evt_valid;
  logic          evt_ready;
  logic [1:0]    evt_chan;
  logic [63:0]   evt_report;
`ifdef HID_COLLECTOR_OVERRUN_EN
  logic [23:0]   overrun;
`endif

  hid_report_collector #(
    .C_channels    (3),
    .C_report_bytes(8),
    .C_disp_bytes  (8),
    .C_timeout_bits(4)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .hid_report_i(hid_report),
    .hid_valid_i (hid_valid),
    .freeze_i    (freeze),
    .clear_i     (clear),
    .display_o   (display),
    .changed_o   (changed),
    .stale_o     (stale),
    .evt_valid_o (evt_valid),
    .evt_ready_i (evt_ready),
    .evt_chan_o  (evt_chan),
    .evt_report_o(evt_report)
`ifdef HID_COLLECTOR_OVERRUN_EN
    ,
    .overrun_o   (overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: latest report per channel, sticky change flags, one pending event.
  logic [63:0] m_store [C];
  bit          m_changed [C];
  int          m_cnt [C];
  int          m_ovr [C];
  bit          m_valid;
  int          m_chan;
  logic [63:0] m_report;
  int          m_rr;
  bit          m_live = 1'b0;

  task automatic model_step();
    bit          nxt [C];
    logic [63:0] rk;
    bit          took, differs, hit, acc, found;
    int          g, c;
    if (!rstn) begin
      for (int k = 0; k < C; k++) begin
        m_store[k] = '0; m_changed[k] = 1'b0; m_cnt[k] = 0; m_ovr[k] = 0;
      end
      m_valid = 1'b0; m_chan = 0; m_report = '0; m_rr = 0; m_live = 1'b1;
      return;
    end
    acc = m_valid && evt_ready;
    for (int k = 0; k < C; k++) begin
      if (hid_valid[k]) m_cnt[k] = 0;
      else if (m_cnt[k] < STALE_MAX) m_cnt[k]++;
    end
    if (clear) begin
      for (int k = 0; k < C; k++) begin
        m_store[k] = '0; m_changed[k] = 1'b0; m_ovr[k] = 0;
      end
      m_valid = 1'b0;
      return;
    end
    for (int k = 0; k < C; k++) begin
      rk      = hid_report[k*64 +: 64];
      took    = hid_valid[k] && !freeze;
      differs = took && (rk != m_store[k]);
      hit     = acc && (m_chan == k);
      if (differs && m_changed[k] && !hit && m_ovr[k] < 255) m_ovr[k]++;
      nxt[k] = differs || (m_changed[k] && !hit);
      if (took) m_store[k] = rk;
    end
    if (m_valid) begin
      if (evt_ready) begin
        m_valid = 1'b0;
        m_rr    = (m_chan + 1) % C;
      end
    end else begin
      found = 1'b0; g = 0;
      for (int n = 0; n < C; n++) begin
        c = (m_rr + n) % C;
        if (!found && m_changed[c]) begin found = 1'b1; g = c; end
      end
      if (found) begin
        m_valid = 1'b1; m_chan = g; m_report = m_store[g];
      end
    end
    for (int k = 0; k < C; k++) m_changed[k] = nxt[k];
  endtask

  task automatic check_model();
    logic [191:0] ed;
    logic [2:0]   ec, es;
    ed = '0; ec = '0; es = '0;
    for (int k = 0; k < C; k++) begin
      ed[k*64 +: 64] = m_store[k];
      ec[k] = m_changed[k];
      es[k] = (m_cnt[k] == STALE_MAX);
    end
    chk("model display", display, ed);
    chk("model changed", 192'(changed), 192'(ec));
    chk("model stale", 192'(stale), 192'(es));
    chk("model evt_valid", 192'(evt_valid), 192'(m_valid));
    if (m_valid) begin
      chk("model evt_chan", 192'(evt_chan), 192'(m_chan));
      chk("model evt_report", 192'(evt_report), 192'(m_report));
    end
`ifdef HID_COLLECTOR_OVERRUN_EN
    for (int k = 0; k < C; k++) chk("model overrun", 192'(overrun[k*8 +: 8]), 192'(m_ovr[k]));
`endif
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_live) check_model();
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_event(input int ch, input logic [63:0] rep, input string nm);
    int n = 0;
    while (!evt_valid && n < 20) begin
      tick();
      n++;
    end
    chk({nm, " valid"}, 192'(evt_valid), 192'(1));
    if (evt_valid) begin
      chk({nm, " chan"}, 192'(evt_chan), 192'(ch));
      chk({nm, " report"}, 192'(evt_report), 192'(rep));
    end
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [63:0] r0;
    logic [63:0] r1;
    logic        frz;
    logic        clr;
    logic        rdy;
    logic [2:0]  x_changed;
    logic        x_valid;
    logic [1:0]  x_chan;
    logic [63:0] x_report;
    logic [63:0] x_d0;
    logic [63:0] x_d1;
  } vec_t;

  vec_t tbl [15];

  localparam logic [63:0] RA = 64'h0102030405060708;
  localparam logic [63:0] RB = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] RC = 64'h1111_2222_3333_4444;
  localparam logic [63:0] RX = 64'hDEAD_0000_0000_0001;
  localparam logic [63:0] RY = 64'hBEEF_0000_0000_0001;

  logic [63:0] pool [4];

  initial begin
    tbl[0]  = '{3'b001, RA, 64'h0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 2'd0, 64'h0, RA, 64'h0};
    tbl[1]  = '{3'b000, RA, 64'h0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b1, 2'd0, RA, RA, 64'h0};
    tbl[2]  = '{3'b000, RA, 64'h0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 64'h0, RA, 64'h0};
    tbl[3]  = '{3'b001, RA, 64'h0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 64'h0, RA, 64'h0};
    tbl[4]  = '{3'b000, RA, 64'h0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 64'h0, RA, 64'h0};
    tbl[5]  = '{3'b010, RA, RB, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 64'h0, RA, 64'h0};
    tbl[6]  = '{3'b010, RA, RB, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 2'd0, 64'h0, RA, RB};
    tbl[7]  = '{3'b000, RA, RB, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 2'd1, RB, RA, RB};
    tbl[8]  = '{3'b001, RC, RB, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1, 2'd1, RB, RC, RB};
    tbl[9]  = '{3'b000, RC, RB, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 2'd0, 64'h0, RC, RB};
    tbl[10] = '{3'b000, RC, RB, 1'b0, 1'b0, 1'b1, 3'b001, 1'b1, 2'd0, RC, RC, RB};
    tbl[11] = '{3'b001, RA, RB, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 2'd0, 64'h0, RA, RB};
    tbl[12] = '{3'b000, RA, RB, 1'b0, 1'b0, 1'b1, 3'b001, 1'b1, 2'd0, RA, RA, RB};
    tbl[13] = '{3'b000, RA, RB, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 64'h0, RA, RB};
    tbl[14] = '{3'b001, RC, RB, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 2'd0, 64'h0, 64'h0, 64'h0};

    pool[0] = 64'h0; pool[1] = RA; pool[2] = RC; pool[3] = RX;

    rstn = 1'b0; hid_report = '0; hid_valid = '0; freeze = 1'b0; clear = 1'b0;
    evt_ready = 1'b1;
    tick(); tick();
    rstn = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle display", display, 192'(0));
      chk("idle changed", 192'(changed), 192'(0));
      chk("idle stale", 192'(stale), 192'(0));
      chk("idle evt_valid", 192'(evt_valid), 192'(0));
    end

    for (int i = 0; i < 15; i++) begin
      hid_valid  = tbl[i].valid;
      hid_report = {64'h0, tbl[i].r1, tbl[i].r0};
      freeze     = tbl[i].frz;
      clear      = tbl[i].clr;
      evt_ready  = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d changed", i), 192'(changed), 192'(tbl[i].x_changed));
      chk($sformatf("tbl%0d evt_valid", i), 192'(evt_valid), 192'(tbl[i].x_valid));
      if (tbl[i].x_valid) begin
        chk($sformatf("tbl%0d evt_chan", i), 192'(evt_chan), 192'(tbl[i].x_chan));
        chk($sformatf("tbl%0d evt_report", i), 192'(evt_report), 192'(tbl[i].x_report));
      end
      chk($sformatf("tbl%0d display0", i), 192'(display[63:0]), 192'(tbl[i].x_d0));
      chk($sformatf("tbl%0d display1", i), 192'(display[127:64]), 192'(tbl[i].x_d1));
    end
    hid_valid = '0; freeze = 1'b0; clear = 1'b0; evt_ready = 1'b1;

    // Two simultaneous changes, consumer stalled, then round-robin rounds.
    reset_pulse();
    evt_ready  = 1'b0;
    hid_valid  = 3'b011;
    hid_report = {64'h0, RY, RX};
    tick();
    hid_valid = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall valid", 192'(evt_valid), 192'(1));
      chk("stall chan", 192'(evt_chan), 192'(0));
      chk("stall report", 192'(evt_report), 192'(RX));
      tick();
    end
    evt_ready = 1'b1;
    tick();
    chk("stall accept", 192'(evt_valid), 192'(0));
    expect_event(1, RY, "stall second");
    tick();
    for (int r = 1; r <= 3; r++) begin
      hid_valid  = 3'b011;
      hid_report = {64'h0, RY + 64'(r), RX + 64'(r)};
      tick();
      hid_valid = '0;
      expect_event(0, RX + 64'(r), "rr first");
      tick();
      expect_event(1, RY + 64'(r), "rr second");
      tick();
    end

    // Stale boundary at 2**4-1 cycles.
    reset_pulse();
    for (int i = 0; i < 14; i++) tick();
    chk("stale before", 192'(stale[1]), 192'(0));
    tick();
    chk("stale at limit", 192'(stale[1]), 192'(1));
    hid_valid = 3'b010;
    tick();
    hid_valid = '0;
    chk("stale cleared", 192'(stale[1]), 192'(0));

    // Three differing reports while stalled, then clear drops the held event.
    reset_pulse();
    evt_ready = 1'b0;
    hid_valid = 3'b001;
    hid_report = {128'h0, 64'h11};
    tick();
    hid_report = {128'h0, 64'h22};
    tick();
    hid_report = {128'h0, 64'h33};
    tick();
    hid_valid = '0;
    chk("hold valid", 192'(evt_valid), 192'(1));
    chk("hold same-cycle report", 192'(evt_report), 192'(64'h22));
`ifdef HID_COLLECTOR_OVERRUN_EN
    chk("overrun count", 192'(overrun[7:0]), 192'(2));
`endif
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear evt_valid", 192'(evt_valid), 192'(0));
    chk("clear display", display, 192'(0));
    chk("clear changed", 192'(changed), 192'(0));
`ifdef HID_COLLECTOR_OVERRUN_EN
    chk("clear overrun", 192'(overrun[7:0]), 192'(0));
`endif
    evt_ready = 1'b1;

    // Randomized phase; the per-cycle model comparison does the checking.
    for (int i = 0; i < 800; i++) begin
      rstn      = ($urandom_range(0, 99) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      freeze    = ($urandom_range(0, 9) == 0);
      evt_ready = $urandom_range(0, 1) == 1;
      for (int k = 0; k < C; k++) begin
        hid_valid[k]           = ($urandom_range(0, 2) == 0);
        hid_report[k*64 +: 64] = pool[$urandom_range(0, 3)];
      end
      tick();
    end
    rstn = 1'b1; hid_valid = '0; clear = 1'b0; freeze = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
